// File: rtl/fft_out_reader.sv
// fft_out_reader: streams a finished FFT frame from the two-port RAM as valid/ready samples; FFT_OUT_BITREV_EN selects bit-reversed addressing
module fft_out_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic [N-1:0]           add_a,
  output logic [N-1:0]           add_b,
  input  logic [2*BIT_WIDTH-1:0] dout_a,
  input  logic [2*BIT_WIDTH-1:0] dout_b,
  output logic                   rd_active,
  output logic [BIT_WIDTH-1:0]   out_real,
  output logic [BIT_WIDTH-1:0]   out_img,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, DONE} state_t;
  localparam logic [N-1:0] LAST_K = {{(N-1){1'b1}}, 1'b0};
  state_t                 state_q, state_d;
  logic [N-1:0]           k_q, k_d;
  logic [2*BIT_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d, sel;
  logic [BIT_WIDTH-1:0]   out_real_q, out_real_d, out_img_q, out_img_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   rd_active_q, rd_active_d, done_q, done_d, send;

  function automatic logic [N-1:0] addr_map(input logic [N-1:0] i);
    logic [N-1:0] r;
`ifdef FFT_OUT_BITREV_EN
    for (int b = 0; b < N; b++) r[b] = i[N-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  assign add_a     = (state_q == FETCH || state_q == SEND0 || state_q == SEND1) ? addr_map(k_q) : '0;
  assign add_b     = (state_q == FETCH || state_q == SEND0 || state_q == SEND1) ? addr_map({k_q[N-1:1], 1'b1}) : '0;
  assign rd_active = rd_active_q;
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

  // next state, pair counter, capture buffer and registered outputs derived from the next state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      IDLE:  if (start) begin
        state_d = FETCH;
        k_d     = '0;
      end
      FETCH: begin
        buf0_d  = dout_a;
        buf1_d  = dout_b;
        state_d = SEND0;
      end
      SEND0: if (out_ready) state_d = SEND1;
      SEND1: if (out_ready) begin
        if (k_q == LAST_K) state_d = DONE;
        else begin
          k_d     = k_q + N'(2);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    send        = state_d == SEND0 || state_d == SEND1;
    sel         = state_d == SEND1 ? buf1_d : buf0_d;
    out_real_d  = send ? sel[2*BIT_WIDTH-1:BIT_WIDTH] : '0;
    out_img_d   = send ? sel[BIT_WIDTH-1:0] : '0;
    out_valid_d = send;
    out_last_d  = state_d == SEND1 && k_d == LAST_K;
    rd_active_d = send || state_d == FETCH;
    done_d      = state_d == DONE;
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      out_real_q  <= '0;
      out_img_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rd_active_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      out_real_q  <= out_real_d;
      out_img_q   <= out_img_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rd_active_q <= rd_active_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: doc/fft_out_reader.md
# fft_out_reader

Streams a completed FFT frame out of the two-port butterfly RAM as a valid/ready sample stream. On `start` it walks output indices 0..2^N-1, fetches two samples per RAM access (one per port), optionally applies bit-reversed addressing so samples leave in natural frequency order, and pulses `done` after the last beat. It sits between the FFT controller/RAM and the downstream magnitude/output logic, and owns the RAM address ports while `rd_active` is high.

## Interface
- `BIT_WIDTH`, 16: width of each real and imaginary component.
- `N`, 9: address width; the frame is 2^N samples. N ≥ 2.

- `clk` input 1: system clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to stream a frame; sampled only in IDLE.
- `add_a` output N: RAM port A read address.
- `add_b` output N: RAM port B read address.
- `dout_a` input 2*BIT_WIDTH: RAM port A data, {real, img}, combinational from `add_a`.
- `dout_b` input 2*BIT_WIDTH: RAM port B data, {real, img}, combinational from `add_b`.
- `rd_active` output 1: reader owns the RAM; the controller holds `we` low while this is high.
- `out_real` output BIT_WIDTH: sample real part.
- `out_img` output BIT_WIDTH: sample imaginary part.
- `out_valid` output 1: output sample valid.
- `out_ready` input 1: consumer accepts the sample this cycle.
- `out_last` output 1: high with the final sample (index 2^N-1).
- `done` output 1: one-cycle pulse after the final handshake.

## Operation
- Pair counter `k` (N bits, always even) selects output indices k and k+1.
- Address map: `add_a` = map(k), `add_b` = map(k+1). map is bit-reversal of N bits (see Configuration).
- Two-entry capture buffer `buf0`, `buf1` (2*BIT_WIDTH each).
- `out_real` = upper BIT_WIDTH bits of the selected buffer entry; `out_img` = lower BIT_WIDTH bits. No arithmetic, no sign handling.
- States:
  - IDLE: `rd_active`=0, `out_valid`=0, addresses 0. If `start`=1, set k=0 and go to FETCH.
  - FETCH: `rd_active`=1. Drive addresses for k; at the clock edge load `buf0`←`dout_a` and `buf1`←`dout_b`, then go to SEND0.
  - SEND0: `out_valid`=1, data = `buf0`. If `out_ready`=1, go to SEND1; otherwise hold with data stable.
  - SEND1: `out_valid`=1, data = `buf1`, `out_last` = (k == 2^N-2). If `out_ready`=1 and this is the last pair, go to DONE. If `out_ready`=1 and not the last pair, set k += 2 and go to FETCH.
  - DONE: `done`=1 for exactly one cycle, `rd_active`=0, then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to restart the frame.
- While `out_valid`=1 and `out_ready`=0, `out_real`, `out_img` and `out_last` stay constant.
- `rd_active` is high in FETCH, SEND0 and SEND1. The RAM contents must not change during that window.

## Timing
- Reset (asserted asynchronously at any time, including mid-frame): state returns to IDLE, k=0, buffers 0, and all outputs are 0 (`add_a`, `add_b`, `rd_active`, `out_real`, `out_img`, `out_valid`, `out_last`, `done`). A partially streamed frame is abandoned.
- All outputs except `add_a` and `add_b` are registered. `add_a`/`add_b` are derived from registered k and the state.
- Latency: `start` sampled at edge t → FETCH in cycle t+1 → first `out_valid` in cycle t+2.
- With `out_ready` held high, each pair takes 3 cycles (FETCH, SEND0, SEND1). A full frame takes 3·2^(N-1) cycles, followed by the `done` cycle. Earliest next accepted `start` is in the cycle after `done`.
- k never wraps: the last pair is detected before increment.

## Configuration
- `FFT_OUT_BITREV_EN` defined: map(i) = bit-reverse of i over N bits. Use this when the FFT writes its results in bit-reversed order, so the stream leaves in natural order.
- Not defined: map(i) = i, for an FFT that writes its results in natural order.

## Test plan
- Reset values: N=3, hold `reset_n`=0 → every output is 0. Release, idle for 5 cycles → `out_valid`=0, `rd_active`=0.
- Bit-reversed order: N=3 with the macro defined, RAM word at address a = {a, ~a}, `out_ready`=1 → samples from addresses 0,4,2,6,1,5,3,7. `out_last` only on the 8th beat. `done` at start+13 cycles.
- Natural order: same bench without the macro → samples from addresses 0..7 in order, same cycle timing.
- Backpressure: drop `out_ready` for 4 cycles in SEND0 and again in SEND1 → data and `out_last` held stable, no sample lost or duplicated, frame completes 8 cycles later.
- Ignored start: pulse `start` during SEND0 of pair 2 → the frame continues unchanged and no second frame follows `done`.
- Reset mid-frame: assert `reset_n`=0 after the 3rd beat → all outputs 0 immediately. A new `start` restarts from address 0.
